// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-byte ALU operation sequencer, LSB first with carry chaining
// Issues one SETTLE-cycle ALU pass per byte and returns the assembled result with a done pulse.
module alu_seq #(
   parameter int MAX_BYTES = 4,
   parameter int SETTLE    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [3:0]             req_op,
   input  logic                   req_invert,
   input  logic                   req_cin,
   input  logic [1:0]             req_len,
   input  logic [8*MAX_BYTES-1:0] req_a,
   input  logic [8*MAX_BYTES-1:0] req_b,
   output logic                   done_valid,
   output logic [8*MAX_BYTES-1:0] done_result,
   output logic [3:0]             done_flags,
   output logic [7:0]             alu_a,
   output logic [7:0]             alu_b,
   output logic [3:0]             alu_op,
   output logic                   alu_n_oe,
   output logic                   alu_invert,
   output logic                   alu_carry_in,
   input  logic [7:0]             alu_result,
   input  logic [3:0]             alu_flags
);

   localparam int W  = 8 * MAX_BYTES;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     op_q, op_d;
   logic           inv_q, inv_d;
   logic           cin_q, cin_d;
   logic [1:0]     len_q, len_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [1:0]     idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   res_q, res_d;
   logic           zacc_q, zacc_d;
   logic [2:0]     clast_q, clast_d;
   logic [W-1:0]   done_result_q, done_result_d;
   logic [3:0]     done_flags_q, done_flags_d;

   logic chained;
   logic is_inc;
   logic capture;
   int   boff;

   // Adder forms 01/10/11 chain through the carry-using form on upper bytes.
   assign chained = op_q[3] && (op_q[1:0] != 2'b00);
   assign is_inc  = op_q[3] && (op_q[1:0] == 2'b11);
   assign boff    = int'(idx_q) * 8;
   assign capture = (state_q == S_EXEC) && (cnt_q == CW'(SETTLE - 1));

   assign done_result = done_result_q;
   assign done_flags  = done_flags_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         inv_q         <= 1'b0;
         cin_q         <= 1'b0;
         len_q         <= '0;
         a_q           <= '0;
         b_q           <= '0;
         idx_q         <= '0;
         cnt_q         <= '0;
         res_q         <= '0;
         zacc_q        <= 1'b0;
         clast_q       <= '0;
         done_result_q <= '0;
         done_flags_q  <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         inv_q         <= inv_d;
         cin_q         <= cin_d;
         len_q         <= len_d;
         a_q           <= a_d;
         b_q           <= b_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         res_q         <= res_d;
         zacc_q        <= zacc_d;
         clast_q       <= clast_d;
         done_result_q <= done_result_d;
         done_flags_q  <= done_flags_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      inv_d         = inv_q;
      cin_d         = cin_q;
      len_d         = len_q;
      a_d           = a_q;
      b_d           = b_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      res_d         = res_q;
      zacc_d        = zacc_q;
      clast_d       = clast_q;
      done_result_d = done_result_q;
      done_flags_d  = done_flags_q;

      req_ready    = 1'b0;
      done_valid   = 1'b0;
      alu_a        = 8'h00;
      alu_b        = 8'h00;
      alu_op       = 4'h0;
      alu_n_oe     = 1'b1;
      alu_invert   = 1'b0;
      alu_carry_in = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d    = req_op;
               inv_d   = req_invert;
               cin_d   = req_cin;
               len_d   = req_len;
               a_d     = req_a;
               b_d     = req_b;
               res_d   = '0;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            alu_n_oe   = 1'b0;
            alu_invert = inv_q;
            alu_a      = a_q[boff +: 8];
            alu_b      = (is_inc && idx_q != 2'd0) ? 8'h00 : b_q[boff +: 8];
            if (chained && idx_q != 2'd0) begin
               alu_op       = {op_q[3:2], 2'b10};
               alu_carry_in = clast_q[0];
            end else begin
               alu_op       = op_q;
               alu_carry_in = cin_q;
            end

            if (capture) begin
               res_d[boff +: 8] = alu_result;
               zacc_d  = (idx_q == 2'd0) ? alu_flags[0] : (zacc_q & alu_flags[0]);
               clast_d = alu_flags[3:1];
               if (idx_q == len_q) begin
                  done_result_d = res_d;
                  done_flags_d  = {alu_flags[3:1], zacc_d};
                  state_d       = S_DONE;
               end else begin
                  idx_d = idx_q + 2'd1;
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DONE: begin
            done_valid = 1'b1;
            state_d    = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-byte operation sequencer that drives the 8-bit `alu` as its initiator. It accepts a 1–4 byte operation request and issues one ALU pass per byte, least-significant byte first. For adder operations it chains the carry between passes. It assembles the result and aggregated flags and returns them with a one-cycle done pulse. It sits between the control unit and the ALU, owning the ALU's `op`/`n_oe`/`invert`/`carry_in` inputs.

## Interface
Parameters:
- `MAX_BYTES`, 4: maximum operand width in bytes.
- `SETTLE`, 2: cycles each byte's inputs are held on the ALU before capture; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  4  ALU opcode for byte 0.
- `req_invert`  in  1  ALU operand swap/invert control, applied to every byte.
- `req_cin`  in  1  carry in for byte 0, and for all bytes of non-adder ops.
- `req_len`  in  2  byte count minus 1.
- `req_a`, `req_b`  in  8*MAX_BYTES  operands, little-endian bytes.
- `done_valid`  out  1  one-cycle pulse: result and flags valid.
- `done_result`  out  8*MAX_BYTES  assembled result; bytes above `req_len` are 0.
- `done_flags`  out  4  {V,S,C,Z}, same bit order as the ALU.
- `alu_a`, `alu_b`  out  8  current byte operands.
- `alu_op`  out  4  opcode to the ALU.
- `alu_n_oe`  out  1  ALU output enable, active-low.
- `alu_invert`  out  1  drives the ALU `invert` input.
- `alu_carry_in`  out  1  drives the ALU `carry_in` input.
- `alu_result`  in  8  ALU result bus.
- `alu_flags`  in  4  ALU flags.

## Operation
- States: IDLE, EXEC, DONE.
- **IDLE**
  - `req_ready`=1 and `alu_n_oe`=1.
  - On `req_valid`&`req_ready`: latch op, invert, cin, len, a and b.
  - Clear the result register; set idx=0 and cnt=0; go to EXEC.
  - `req_valid` is ignored while `rst`=1.
- **EXEC**
  - Drive `alu_n_oe`=0, `alu_invert`=latched invert, `alu_a`=a[idx], `alu_b`=b[idx].
  - If the op is an increment (op[3]=1, op[1:0]=11) and idx>0, drive `alu_b`=0.
  - cnt counts 0..SETTLE-1.
  - At the edge ending cnt=SETTLE-1:
    - Write `alu_result` into result byte idx.
    - Set zacc = zacc & `alu_flags`[0]; on idx=0, zacc = `alu_flags`[0].
    - Store `alu_flags`[3:1] into clast.
  - After the capture: if idx==len go to DONE; otherwise idx+1, cnt=0, stay in EXEC.
- **Opcode per byte**
  - Byte 0 uses the latched op.
  - Adder ops (op[3]=1) with op[1:0] ∈ {01,10,11}: bytes idx>0 use {op[3:2],2'b10}, i.e. the carry-using form of the same add/sub.
  - Adder ops with op[1:0]=00, and all non-adder ops (op[3]=0): every byte uses the latched op unchanged, with no chaining.
- **alu_carry_in**
  - Byte 0: req_cin.
  - Chained bytes idx>0: `alu_flags`[1] captured from byte idx-1.
  - Unchained ops: req_cin on every byte.
  - The ALU gates carry internally; the sequencer does not mask it.
- **DONE** (one cycle)
  - `done_valid`=1, `done_result`=result register.
  - `done_flags` = {V,S,C from last byte, Z=zacc}.
  - Then return to IDLE.
- **Outputs between pulses:** `done_result`/`done_flags` hold their values until the next capture; only `done_valid` is a pulse.
- **Reset** (async, any state):
  - State goes to IDLE; no done pulse for an aborted operation.
  - `req_ready`=1, `done_valid`=0, `done_result`=0, `done_flags`=0.
  - `alu_n_oe`=1, `alu_a`=`alu_b`=0, `alu_op`=0, `alu_invert`=0, `alu_carry_in`=0.
- **Outputs in IDLE/DONE:** `alu_a`/`alu_b`/`alu_op`/`alu_invert`/`alu_carry_in` are 0.

## Timing
- Accept edge E0: EXEC begins in the cycle after E0.
- Byte k occupies cycles [k*SETTLE+1 .. (k+1)*SETTLE] after E0, with inputs stable for all SETTLE cycles.
- `done_valid` is high in cycle (len+1)*SETTLE+1 after E0.
  - With SETTLE=2 and len=3: high in cycle 9.
- The next accept is possible no earlier than the cycle after DONE; `req_ready` is 0 in EXEC and DONE.
- ALU combinational delay (≈140 ns worst-case through flags) must be < SETTLE*clock period; integration picks SETTLE accordingly.
- `alu_flags`[1] from byte k-1 is registered before byte k starts, so there is no combinational loop through the ALU.

## Test plan
- **16-bit add:**
  - Stimulus: len=1, op=4'b1001, a=0x12FF, b=0x0001, cin=0.
  - Bytes: byte0 op 1001 → 0x00, C=1; byte1 op 1010, carry_in=1 → 0x13.
  - Required: result 0x1300, Z=0, C=0.
- **Zero aggregation:**
  - Stimulus: len=1, op=1001, a=0x0100, b=0xFF00.
  - Required: result 0x0000, Z=1, C=1.
  - Repeat with a=0x0101, b=0xFF00 → Z=0.
- **Increment:**
  - Stimulus: len=1, op=1011, a=0x00FF, b=0xAAAA.
  - Required: byte1 drives `alu_b`=0; result 0x0100, C=0.
- **Unchained op:**
  - Stimulus: len=3, op=4'b0001 (AND), a=0xF0F0F0F0, b=0xFF00FF00.
  - Required: every byte uses op 0001; result 0xF000F000; upper result bytes are 0 when len<3.
- **Latency/handshake:**
  - Stimulus: SETTLE=2, `req_valid` held high, len=3.
  - Required: `done_valid` in cycle 9 after accept; `req_ready` low until IDLE; second request accepted the cycle after DONE.
- **Reset mid-operation:**
  - Stimulus: assert `rst` during byte 1 of a 4-byte op.
  - Required: outputs immediately take their reset values; no `done_valid`; a fresh request after release completes correctly.
